// File: rtl/pll_pkg.sv
// Shared constants and helpers for the pll_clk_div divider family.
// Optional tick outputs are enabled by defining PLL_TICK_EN.
package pll_pkg;

  localparam int unsigned ClkFreqHz = 50_000_000;
  localparam int unsigned FAHz      = 100_000;
  localparam int unsigned FBHz      = 50_000;
  localparam int unsigned FCHz      = 1_600;

  // Half-period in input cycles; a zero target frequency yields 0 so elaboration can flag it.
  function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned f_hz);
    if (f_hz == 0) begin
      return 0;
    end
    return clk_hz / (2 * f_hz);
  endfunction

  // Counter holds 0 .. half-1, never fewer than one bit.
  function automatic int unsigned calc_width(input int unsigned half);
    if (half <= 2) begin
      return 1;
    end
    return $clog2(half);
  endfunction

endpackage

// File: rtl/clk_div_toggle.sv
// Toggle-counter divider: output flips every Half input cycles, giving a 2*Half period.
// With PLL_TICK_EN, tick pulses for one cycle alongside each rising edge of clk_out.
module clk_div_toggle
  import pll_pkg::*;
#(
  parameter int unsigned Half = 250
) (
  input  logic clk,
  input  logic rst,
`ifdef PLL_TICK_EN
  output logic tick,
`endif
  output logic clk_out
);

  localparam int unsigned Width = calc_width(Half);
  localparam logic [Width-1:0] CntLast = Width'(Half - 1);

  if (Half < 1) begin : g_bad_half
    $error("clk_div_toggle: Half must be at least 1");
  end

  logic [Width-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CntLast);
    cnt_d = cnt_q + Width'(1);
    out_d = out_q;
    if (wrap) begin
      cnt_d = '0;
      out_d = ~out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign clk_out = out_q;

`ifdef PLL_TICK_EN
  logic tick_q, tick_d;

  // Registered alongside out_q so the pulse lands in the cycle the output goes high.
  always_comb begin
    tick_d = wrap & ~out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: rtl/pll_clk_div.sv
// Three independent square-wave dividers from the board clock (no analog PLL inside).
// Defining PLL_TICK_EN adds one-cycle rising-edge tick outputs per divided clock.
module pll_clk_div
  import pll_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = ClkFreqHz,
  parameter int unsigned F_A_HZ      = FAHz,
  parameter int unsigned F_B_HZ      = FBHz,
  parameter int unsigned F_C_HZ      = FCHz
) (
  input  logic clk,
  input  logic rst,
`ifdef PLL_TICK_EN
  output logic tick100khz,
  output logic tick50khz,
  output logic tick1_6khz,
`endif
  output logic clk100khz,
  output logic clk50khz,
  output logic clk1_6khz
);

  localparam int unsigned HalfA = calc_half(CLK_FREQ_HZ, F_A_HZ);
  localparam int unsigned HalfB = calc_half(CLK_FREQ_HZ, F_B_HZ);
  localparam int unsigned HalfC = calc_half(CLK_FREQ_HZ, F_C_HZ);

  clk_div_toggle #(
    .Half(HalfA)
  ) u_div_a (
    .clk     (clk),
    .rst     (rst),
`ifdef PLL_TICK_EN
    .tick    (tick100khz),
`endif
    .clk_out (clk100khz)
  );

  clk_div_toggle #(
    .Half(HalfB)
  ) u_div_b (
    .clk     (clk),
    .rst     (rst),
`ifdef PLL_TICK_EN
    .tick    (tick50khz),
`endif
    .clk_out (clk50khz)
  );

  clk_div_toggle #(
    .Half(HalfC)
  ) u_div_c (
    .clk     (clk),
    .rst     (rst),
`ifdef PLL_TICK_EN
    .tick    (tick1_6khz),
`endif
    .clk_out (clk1_6khz)
  );

endmodule

// File: tb/tb_pll_clk_div.sv
// Directed bench for pll_clk_div: default build plus a small-HALF parameter override.
module tb_pll_clk_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk100khz, clk50khz, clk1_6khz;
  logic s_a, s_b, s_c;
`ifdef PLL_TICK_EN
  logic tick100khz, tick50khz, tick1_6khz;
  logic s_ta, s_tb, s_tc;
`endif

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  pll_clk_div dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PLL_TICK_EN
    .tick100khz(tick100khz),
    .tick50khz (tick50khz),
    .tick1_6khz(tick1_6khz),
`endif
    .clk100khz (clk100khz),
    .clk50khz  (clk50khz),
    .clk1_6khz (clk1_6khz)
  );

  // HALF = 5, 10, 50
  pll_clk_div #(
    .CLK_FREQ_HZ(1000),
    .F_A_HZ     (100),
    .F_B_HZ     (50),
    .F_C_HZ     (10)
  ) dut_small (
    .clk       (clk),
    .rst       (rst),
`ifdef PLL_TICK_EN
    .tick100khz(s_ta),
    .tick50khz (s_tb),
    .tick1_6khz(s_tc),
`endif
    .clk100khz (s_a),
    .clk50khz  (s_b),
    .clk1_6khz (s_c)
  );

  // Edges with rst=1 since the last reset; output edges are stamped with this count.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int a_rise[$], a_fall[$], b_rise[$], c_rise[$], c_fall[$];
  int s_a_rise[$], s_a_fall[$], s_b_rise[$], s_c_rise[$];
  logic pa, pb, pc, psa, psb, psc;
  logic c_at_400 = 1'b0;
  int tick_a_cnt = 0, tick_b_cnt = 0, tick_c_cnt = 0, tick_err = 0;

  always @(negedge clk) begin
    pa  <= clk100khz;
    pb  <= clk50khz;
    pc  <= clk1_6khz;
    psa <= s_a;
    psb <= s_b;
    psc <= s_c;
    if (!rst) begin
      a_rise.delete(); a_fall.delete(); b_rise.delete(); c_rise.delete(); c_fall.delete();
      s_a_rise.delete(); s_a_fall.delete(); s_b_rise.delete(); s_c_rise.delete();
    end else begin
      if (clk100khz && !pa) a_rise.push_back(cyc);
      if (!clk100khz && pa) a_fall.push_back(cyc);
      if (clk50khz && !pb) b_rise.push_back(cyc);
      if (clk1_6khz && !pc) c_rise.push_back(cyc);
      if (!clk1_6khz && pc) c_fall.push_back(cyc);
      if (s_a && !psa) s_a_rise.push_back(cyc);
      if (!s_a && psa) s_a_fall.push_back(cyc);
      if (s_b && !psb) s_b_rise.push_back(cyc);
      if (s_c && !psc) s_c_rise.push_back(cyc);
      if (cyc == 20000) c_at_400 <= clk1_6khz;
`ifdef PLL_TICK_EN
      if (tick100khz && cyc <= 20000) tick_a_cnt <= tick_a_cnt + 1;
      if (tick50khz && cyc <= 20000)  tick_b_cnt <= tick_b_cnt + 1;
      if (tick1_6khz && cyc <= 20000) tick_c_cnt <= tick_c_cnt + 1;
      tick_err <= tick_err
                + int'(tick100khz !== (clk100khz && !pa))
                + int'(tick50khz  !== (clk50khz && !pb))
                + int'(tick1_6khz !== (clk1_6khz && !pc))
                + int'(s_ta !== (s_a && !psa))
                + int'(s_tb !== (s_b && !psb))
                + int'(s_tc !== (s_c && !psc));
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int bad;
    int n;
    bit found;

    rst = 1'b0;
    step(3);
    check_eq("rst_a", 32'(clk100khz), 0);
    check_eq("rst_b", 32'(clk50khz), 0);
    check_eq("rst_c", 32'(clk1_6khz), 0);
    check_eq("rst_sa", 32'(s_a), 0);
    check_eq("rst_sb", 32'(s_b), 0);
    check_eq("rst_sc", 32'(s_c), 0);
`ifdef PLL_TICK_EN
    check_eq("rst_ticks", 32'({tick100khz, tick50khz, tick1_6khz}), 0);
`endif

    rst = 1'b1;
    step(47000);

    check_eq("a_first_rise", at(a_rise, 0), 250);
    check_eq("a_first_fall", at(a_fall, 0), 500);
    check_eq("a_second_rise", at(a_rise, 1), 750);
    check_eq("b_first_rise", at(b_rise, 0), 500);
    check_eq("b_period", at(b_rise, 1) - at(b_rise, 0), 1000);
    check_eq("c_first_rise", at(c_rise, 0), 15625);
    check_eq("c_high_at_400us", 32'(c_at_400), 1);
    check_eq("c_first_fall", at(c_fall, 0), 31250);
    check_eq("c_second_rise", at(c_rise, 1), 46875);

    n = 0;
    foreach (a_rise[i]) if (a_rise[i] <= 20000) n++;
    check_eq("a_rises_400us", n, 40);
    n = 0;
    foreach (b_rise[i]) if (b_rise[i] <= 20000) n++;
    check_eq("b_rises_400us", n, 20);
    check_eq("a_rises_total", a_rise.size(), 94);
    check_eq("a_falls_total", a_fall.size(), 94);
    bad = 0;
    foreach (a_fall[i]) begin
      if (a_fall[i] - at(a_rise, i) != 250) bad++;
      if (i + 1 < a_rise.size() && a_rise[i+1] - a_fall[i] != 250) bad++;
    end
    check_eq("a_duty_violations", bad, 0);

    check_eq("small_a_first_rise", at(s_a_rise, 0), 5);
    check_eq("small_a_first_fall", at(s_a_fall, 0), 10);
    check_eq("small_a_second_rise", at(s_a_rise, 1), 15);
    check_eq("small_b_first_rise", at(s_b_rise, 0), 10);
    check_eq("small_c_first_rise", at(s_c_rise, 0), 50);

`ifdef PLL_TICK_EN
    check_eq("tick_a_count", tick_a_cnt, 40);
    check_eq("tick_b_count", tick_b_cnt, 20);
    check_eq("tick_c_count", tick_c_cnt, 1);
    check_eq("tick_alignment_errors", tick_err, 0);
`endif

    // Land on 100 kHz counter value 137 while that output is high.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (cyc % 500 == 387) found = 1'b1;
      else step(1);
    end
    check_eq("midop_wait", 32'(found), 1);
    check_eq("midop_a_high_before", 32'(clk100khz), 1);

    rst = 1'b0;
    step(1);
    check_eq("midop_a_forced", 32'(clk100khz), 0);
    check_eq("midop_b_forced", 32'(clk50khz), 0);
    check_eq("midop_c_forced", 32'(clk1_6khz), 0);
    check_eq("midop_small_forced", 32'({s_a, s_b, s_c}), 0);
    step(2);
    rst = 1'b1;
    step(600);
    check_eq("midop_a_rise", at(a_rise, 0), 250);
    check_eq("midop_a_fall", at(a_fall, 0), 500);
    check_eq("midop_b_rise", at(b_rise, 0), 500);
    check_eq("midop_small_a_rise", at(s_a_rise, 0), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
